ex_issue_stage: RTL and testbench

Registered issue stage between decode/register-read and the execute ALU. It decodes RV32I integer instructions (OP, OP-IMM, LUI, AUIPC) into the 4-bit ALU operation code, resolves operands (register, immediate, PC, write-back forwarding) and holds them in a valid/ready pipeline register. The register drives the ALU's `A`, `B` and `ALUOp` inputs directly.

---
 rtl/alu_pkg.sv | 55 +++++
 rtl/ex_issue_stage_if.sv | 36 +++
 rtl/alu_decode.sv | 54 +++++
 rtl/ex_issue_stage.sv | 96 +++++++++
 tb/tb_ex_issue_stage.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU encodings and the decoded-instruction bundle passed from
// alu_decode to the issue stage.
package alu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_e;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  typedef enum logic [1:0] {ASEL_RS1, ASEL_PC, ASEL_ZERO} a_sel_e;
  typedef enum logic [1:0] {BSEL_RS2, BSEL_IMM, BSEL_ZERO} b_sel_e;

  typedef struct packed {
    aluop_e            aluop;
    a_sel_e            a_sel;
    b_sel_e            b_sel;
    logic [XLEN-1:0]   imm;
    logic [4:0]        rd;
    logic              reg_we;
    logic              illegal;
  } dec_t;

  // funct3 -> ALU op; alt is instr[30], sub_ok is false for OP-IMM (no SUBI)
  function automatic aluop_e f3_aluop(input logic [2:0] f3, input logic alt,
                                      input logic sub_ok);
    aluop_e r;
    case (f3)
      3'b000:  r = (alt && sub_ok) ? ALU_SUB : ALU_ADD;
      3'b001:  r = ALU_SLL;
      3'b010:  r = ALU_SLT;
      3'b011:  r = ALU_SLTU;
      3'b100:  r = ALU_XOR;
      3'b101:  r = alt ? ALU_SRA : ALU_SRL;
      3'b110:  r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ex_issue_stage_if.sv
// Upstream/downstream signal bundle of the issue stage; slave is the stage's view.
interface ex_issue_stage_if;
  import alu_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            fwd_we;
  logic [4:0]      fwd_rd;
  logic [XLEN-1:0] fwd_data;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] A;
  logic [XLEN-1:0] B;
  logic [3:0]      ALUOp;
  logic [4:0]      rd;
  logic            reg_we;
  logic            illegal;

  modport master (
    output in_valid, instr, pc, rs1_data, rs2_data, fwd_we, fwd_rd, fwd_data,
           flush, out_ready,
    input  in_ready, out_valid, A, B, ALUOp, rd, reg_we, illegal
  );

  modport slave (
    input  in_valid, instr, pc, rs1_data, rs2_data, fwd_we, fwd_rd, fwd_data,
           flush, out_ready,
    output in_ready, out_valid, A, B, ALUOp, rd, reg_we, illegal
  );

endinterface

// File: rtl/alu_decode.sv
// Combinational RV32I integer decode (OP, OP-IMM, LUI, AUIPC) into the
// ALU op, operand selects and immediate.
module alu_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr_i,
  output dec_t        dec_o
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic       is_shift;

  assign opc      = instr_i[6:0];
  assign f3       = instr_i[14:12];
  assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

  always_comb begin
    dec_o.aluop   = ALU_ADD;
    dec_o.a_sel   = ASEL_ZERO;
    dec_o.b_sel   = BSEL_ZERO;
    dec_o.imm     = '0;
    dec_o.rd      = instr_i[11:7];
    dec_o.reg_we  = 1'b0;
    dec_o.illegal = 1'b0;
    case (opc)
      OPC_OP: begin
        dec_o.aluop = f3_aluop(f3, instr_i[30], 1'b1);
        dec_o.a_sel = ASEL_RS1;
        dec_o.b_sel = BSEL_RS2;
      end
      OPC_OPIMM: begin
        dec_o.aluop = f3_aluop(f3, instr_i[30], 1'b0);
        dec_o.a_sel = ASEL_RS1;
        dec_o.b_sel = BSEL_IMM;
        // shift immediates carry only shamt; funct7 bits must not leak into B
        dec_o.imm   = is_shift ? {27'b0, instr_i[24:20]}
                               : {{20{instr_i[31]}}, instr_i[31:20]};
      end
      OPC_LUI: begin
        dec_o.b_sel = BSEL_IMM;
        dec_o.imm   = {instr_i[31:12], 12'b0};
      end
      OPC_AUIPC: begin
        dec_o.a_sel = ASEL_PC;
        dec_o.b_sel = BSEL_IMM;
        dec_o.imm   = {instr_i[31:12], 12'b0};
      end
      default: dec_o.illegal = 1'b1;
    endcase
    dec_o.reg_we = !dec_o.illegal && (instr_i[11:7] != 5'd0);
  end

endmodule

// File: rtl/ex_issue_stage.sv
// Issue stage: decode, forward-resolve rs1/rs2, select operands and hold
// them in a single valid/ready register feeding the ALU.
module ex_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  ex_issue_stage_if.slave io
);

  dec_t                       dec;
  logic [1:0][4:0]            src_idx;
  logic [1:0][XLEN-1:0]       src_rdata;
  logic [1:0][XLEN-1:0]       src_val;
  logic [XLEN-1:0]            a_d, b_d;
  logic                       capture;

  logic                       out_valid_q;
  logic [XLEN-1:0]            a_q, b_q;
  logic [3:0]                 aluop_q;
  logic [4:0]                 rd_q;
  logic                       reg_we_q;
  logic                       illegal_q;

  alu_decode u_dec (
    .instr_i (io.instr),
    .dec_o   (dec)
  );

  assign src_idx[0]   = io.instr[19:15];
  assign src_idx[1]   = io.instr[24:20];
  assign src_rdata[0] = io.rs1_data;
  assign src_rdata[1] = io.rs2_data;

  // x0 wins over forwarding so a stray write-back to x0 can never leak in
  for (genvar g = 0; g < 2; g++) begin : g_src
    assign src_val[g] = (src_idx[g] == 5'd0)                    ? '0 :
                        (io.fwd_we && io.fwd_rd == src_idx[g]) ? io.fwd_data :
                                                                  src_rdata[g];
  end

  always_comb begin
    a_d = '0;
    b_d = '0;
    case (dec.a_sel)
      ASEL_RS1: a_d = src_val[0];
      ASEL_PC:  a_d = io.pc;
      default:  a_d = '0;
    endcase
    case (dec.b_sel)
      BSEL_RS2: b_d = src_val[1];
      BSEL_IMM: b_d = dec.imm;
      default:  b_d = '0;
    endcase
  end

  assign io.in_ready = !out_valid_q || io.out_ready;
  assign capture     = io.in_valid && io.in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      aluop_q     <= '0;
      rd_q        <= '0;
      reg_we_q    <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      if (io.flush)         out_valid_q <= 1'b0;
      else if (capture)     out_valid_q <= 1'b1;
      else if (io.out_ready) out_valid_q <= 1'b0;

      // a flushed capture is dropped entirely, datapath included
      if (capture && !io.flush) begin
        a_q       <= a_d;
        b_q       <= b_d;
        aluop_q   <= dec.aluop;
        rd_q      <= dec.rd;
        reg_we_q  <= dec.reg_we;
        illegal_q <= dec.illegal;
      end
    end
  end

  assign io.out_valid = out_valid_q;
  assign io.A         = a_q;
  assign io.B         = b_q;
  assign io.ALUOp     = aluop_q;
  assign io.rd        = rd_q;
  assign io.reg_we    = reg_we_q;
  assign io.illegal   = illegal_q;

endmodule

// File: tb/tb_ex_issue_stage.sv
// Directed + randomized bench for ex_issue_stage against a mnemonic-level
// reference model of the issue slot.
module tb_ex_issue_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_issue_stage_if bus ();

  ex_issue_stage #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // model of the held slot
  logic        m_valid;
  logic [31:0] m_A, m_B;
  logic [3:0]  m_op;
  logic [4:0]  m_rd;
  logic        m_we, m_ill;

  // funct3 -> op number: ADD SLL SLT SLTU XOR SRL OR AND
  localparam int OPTAB [8] = '{0, 5, 8, 9, 4, 6, 3, 2};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rval(input logic [4:0] idx, input logic [31:0] rf,
                                       input logic fwe, input logic [4:0] frd,
                                       input logic [31:0] fd);
    if (idx == 0) return 32'd0;
    if (fwe && frd == idx) return fd;
    return rf;
  endfunction

  task automatic ref_issue(input logic [31:0] ins, input logic [31:0] pcv,
                           input logic [31:0] r1, input logic [31:0] r2,
                           input logic fwe, input logic [4:0] frd, input logic [31:0] fd,
                           output logic [31:0] ea, output logic [31:0] eb,
                           output logic [3:0] eop, output logic ewe, output logic eill);
    int f3;
    logic alt;
    logic [31:0] v1, v2, immI, immU, shamt;
    f3    = int'(ins[14:12]);
    alt   = ins[30];
    v1    = rval(ins[19:15], r1, fwe, frd, fd);
    v2    = rval(ins[24:20], r2, fwe, frd, fd);
    immI  = $signed(ins) >>> 20;
    immU  = ins & 32'hFFFF_F000;
    shamt = (ins >> 20) & 32'd31;
    ea = 0; eb = 0; eop = 0; eill = 0;
    if (ins[6:0] == 7'h33) begin
      ea = v1; eb = v2; eop = 4'(OPTAB[f3]);
      if (alt && f3 == 0) eop = 1;
      if (alt && f3 == 5) eop = 7;
    end else if (ins[6:0] == 7'h13) begin
      ea = v1; eop = 4'(OPTAB[f3]);
      eb = (f3 == 1 || f3 == 5) ? shamt : immI;
      if (alt && f3 == 5) eop = 7;
    end else if (ins[6:0] == 7'h37) begin
      eb = immU;
    end else if (ins[6:0] == 7'h17) begin
      ea = pcv; eb = immU;
    end else begin
      eill = 1;
    end
    ewe = !eill && ins[11:7] != 0;
  endtask

  task automatic check_out();
    chk("out_valid", {31'b0, bus.out_valid}, {31'b0, m_valid});
    if (m_valid) begin
      chk("A", bus.A, m_A);
      chk("B", bus.B, m_B);
      chk("ALUOp", {28'b0, bus.ALUOp}, {28'b0, m_op});
      chk("rd", {27'b0, bus.rd}, {27'b0, m_rd});
      chk("reg_we", {31'b0, bus.reg_we}, {31'b0, m_we});
      chk("illegal", {31'b0, bus.illegal}, {31'b0, m_ill});
    end
  endtask

  task automatic check_zero(input string pfx);
    chk({pfx, "_out_valid"}, {31'b0, bus.out_valid}, 32'd0);
    chk({pfx, "_A"}, bus.A, 32'd0);
    chk({pfx, "_B"}, bus.B, 32'd0);
    chk({pfx, "_ALUOp"}, {28'b0, bus.ALUOp}, 32'd0);
    chk({pfx, "_rd"}, {27'b0, bus.rd}, 32'd0);
    chk({pfx, "_reg_we"}, {31'b0, bus.reg_we}, 32'd0);
    chk({pfx, "_illegal"}, {31'b0, bus.illegal}, 32'd0);
  endtask

  // called at a negedge with inputs already driven; advances one cycle
  task automatic step();
    logic exp_rdy, cap;
    logic [31:0] ea, eb;
    logic [3:0] eop;
    logic ewe, eill;
    #1;
    exp_rdy = !m_valid || bus.out_ready;
    chk("in_ready", {31'b0, bus.in_ready}, {31'b0, exp_rdy});
    cap = bus.in_valid && exp_rdy;
    if (bus.flush) m_valid = 0;
    else if (cap) begin
      ref_issue(bus.instr, bus.pc, bus.rs1_data, bus.rs2_data,
                bus.fwd_we, bus.fwd_rd, bus.fwd_data, ea, eb, eop, ewe, eill);
      m_valid = 1; m_A = ea; m_B = eb; m_op = eop;
      m_rd = bus.instr[11:7]; m_we = ewe; m_ill = eill;
    end else if (bus.out_ready) m_valid = 0;
    @(posedge clk);
    @(negedge clk);
    check_out();
  endtask

  task automatic drv(input logic iv, input logic [31:0] ins, input logic [31:0] r1,
                     input logic [31:0] r2, input logic fwe, input logic [4:0] frd,
                     input logic [31:0] fd, input logic fl, input logic ordy);
    bus.in_valid = iv;   bus.instr = ins;
    bus.rs1_data = r1;   bus.rs2_data = r2;
    bus.fwd_we = fwe;    bus.fwd_rd = frd;  bus.fwd_data = fd;
    bus.flush = fl;      bus.out_ready = ordy;
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 9);
    w[19:15] = 5'($urandom_range(0, 3));
    w[11:7]  = 5'($urandom_range(0, 3));
    if (k <= 2) begin
      w[6:0] = 7'h33; w[24:20] = 5'($urandom_range(0, 3));
      w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
    end else if (k <= 5) begin
      w[6:0] = 7'h13;
      if (w[14:12] == 3'd1 || w[14:12] == 3'd5)
        w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
    end else if (k == 6) w[6:0] = 7'h37;
    else if (k == 7) w[6:0] = 7'h17;
    else if (k == 9) begin
      w[6:0] = 7'h33; w[24:20] = 5'($urandom_range(0, 3));
    end
    return w;
  endfunction

  initial begin
    m_valid = 0; m_A = 0; m_B = 0; m_op = 0; m_rd = 0; m_we = 0; m_ill = 0;
    rst = 1'b1;
    bus.pc = 32'h0000_1000;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    // SUB x3,x1,x2
    drv(1, 32'h402081B3, 10, 3, 0, 0, 0, 0, 1); step();
    chk("sub_A", bus.A, 32'd10);
    chk("sub_B", bus.B, 32'd3);
    chk("sub_op", {28'b0, bus.ALUOp}, 32'd1);
    chk("sub_rd", {27'b0, bus.rd}, 32'd3);
    chk("sub_we", {31'b0, bus.reg_we}, 32'd1);

    // SRAI x5,x6,4 then ADDI x5,x6,-1
    drv(1, 32'h40435293, 32'h8000_0000, 0, 0, 0, 0, 0, 1); step();
    chk("srai_op", {28'b0, bus.ALUOp}, 32'd7);
    chk("srai_B", bus.B, 32'd4);
    drv(1, 32'hFFF30293, 5, 0, 0, 0, 0, 0, 1); step();
    chk("addi_B", bus.B, 32'hFFFF_FFFF);

    // forwarding into rs1, and x0 never forwarded
    drv(1, 32'h002081B3, 0, 7, 1, 1, 32'h55, 0, 1); step();
    chk("fwd_A", bus.A, 32'h55);
    drv(1, 32'h002001B3, 9, 7, 1, 0, 32'h55, 0, 1); step();
    chk("fwd_x0_A", bus.A, 32'd0);

    // stall for 5 cycles then release with a simultaneous capture
    drv(1, 32'h402081B3, 10, 3, 0, 0, 0, 0, 1); step();
    drv(1, 32'hFFF30293, 7, 0, 1, 6, 32'h99, 0, 0);
    repeat (5) begin
      step();
      chk("stall_in_ready", {31'b0, bus.in_ready}, 32'd0);
      chk("stall_A", bus.A, 32'd10);
    end
    drv(1, 32'hFFF30293, 7, 0, 0, 0, 0, 0, 1); step();
    chk("release_A", bus.A, 32'd7);
    chk("release_B", bus.B, 32'hFFFF_FFFF);

    // flush beats a simultaneous capture
    drv(1, 32'h402081B3, 10, 3, 0, 0, 0, 1, 1); step();
    chk("flush_valid", {31'b0, bus.out_valid}, 32'd0);

    // illegal opcode
    drv(1, 32'h0000_007F, 1, 2, 0, 0, 0, 0, 1); step();
    chk("ill_flag", {31'b0, bus.illegal}, 32'd1);
    chk("ill_we", {31'b0, bus.reg_we}, 32'd0);
    chk("ill_op", {28'b0, bus.ALUOp}, 32'd0);

    // async reset in the middle of a stall
    drv(1, 32'h402081B3, 10, 3, 0, 0, 0, 0, 1); step();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0); step();
    #2 rst = 1'b1;
    #1 check_zero("midrst");
    m_valid = 0;
    @(negedge clk);
    rst = 1'b0;
    drv(1, 32'h402081B3, 10, 3, 0, 0, 0, 0, 1); step();
    chk("post_rst_A", bus.A, 32'd10);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      bus.pc = $urandom;
      drv($urandom_range(0, 3) != 0, rnd_instr(), $urandom, $urandom,
          $urandom_range(0, 1) != 0, 5'($urandom_range(0, 3)), $urandom,
          $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
